// File: rtl/ysyx_23060203_lsu_if.sv
// Bundles for the load/store unit.
//
// ysyx_23060203_lsu_exu_if : EXU <-> LSU request/response channel
//   master = EXU (drives request, accepts response)
//   slave  = LSU (accepts request, drives response)
//   req_valid/req_ready, req_wen, req_func[2:0], req_addr[31:0], req_wdata[31:0]
//   rsp_valid/rsp_ready, rsp_rdata[31:0], rsp_err
//
// ysyx_23060203_lsu_mem_if : LSU <-> data memory bus
//   master = LSU (issues word-aligned request with byte strobe)
//   slave  = memory array (accepts request, returns one-cycle response)
//   req_valid/req_ready, wen, addr[31:0], wdata[31:0], wmask[3:0]
//   rsp_valid, rsp_rdata[31:0], rsp_err

interface ysyx_23060203_lsu_exu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_func;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wen, req_func, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_func, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface ysyx_23060203_lsu_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, wen, addr, wdata, wmask,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, wen, addr, wdata, wmask,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ysyx_23060203_lsu.sv
// Load/store unit: initiator side of the data-memory port.
// Accepts one load/store from EXU, issues one word-aligned bus request with a
// byte strobe, aligns and sign/zero-extends read data, and returns a single
// response. One transaction in flight; every output is a flop.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   exu  : EXU request/response channel (slave modport)
//   mem  : data-memory bus (master modport)
//
// Parameters:
//   TIMEOUT_CYCLES : cycles spent in REQ+WAIT before the transaction is
//                    aborted with an error (only with LSU_TIMEOUT_EN)
//
// Build option:
//   `define LSU_TIMEOUT_EN  -> enables the REQ/WAIT watchdog counter.
//   Undefined (default)     -> REQ/WAIT wait indefinitely.

module ysyx_23060203_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_23060203_lsu_exu_if.slave        exu,
  ysyx_23060203_lsu_mem_if.master       mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Misaligned H/W accesses and unsupported funct3 codes are rejected
  // without touching the bus.
  function automatic logic f_illegal(input logic wen, input logic [2:0] func,
                                     input logic [1:0] off);
    logic bad_func;
    if (wen) bad_func = func[2] || (func[1:0] == 2'b11);
    else     bad_func = (func == 3'b011) || (func == 3'b110) || (func == 3'b111);
    return bad_func || ((func[1:0] == 2'b01) && off[0]) ||
           ((func[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] f_wmask(input logic wen, input logic [2:0] func,
                                         input logic [1:0] off);
    logic [3:0] base;
    if (!wen) return 4'b1111;
    case (func[1:0])
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] func, input logic [1:0] off,
                                         input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (func)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  state_e      r_state;
  state_e      w_state_nxt;
  logic        w_accept;
  logic        w_illegal;
  logic        w_timeout;
  logic        w_mem_done;

  logic [2:0]  r_func;
  logic [1:0]  r_off;
  logic        r_wen;

  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_mem_req_valid;
  logic        r_mem_wen;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wmask;

  assign w_illegal  = f_illegal(exu.req_wen, exu.req_func, exu.req_addr[1:0]);
  // Memory responses only count while a request is outstanding.
  assign w_mem_done = (r_state == S_WAIT) && mem.rsp_valid;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         r_tmo_cnt <= '0;
    else if (w_accept)                               r_tmo_cnt <= '0;
    else if ((r_state == S_REQ) || (r_state == S_WAIT)) r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // Fires during the TIMEOUT_CYCLES-th cycle spent in REQ/WAIT.
  assign w_timeout = ((r_state == S_REQ) || (r_state == S_WAIT)) &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
  assign w_timeout    = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (exu.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_illegal ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (w_timeout)          w_state_nxt = S_RESP;
        else if (mem.req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem.rsp_valid || w_timeout) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (exu.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_req_ready     <= 1'b1;
      r_rsp_valid     <= 1'b0;
      r_rsp_rdata     <= '0;
      r_rsp_err       <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_wen       <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_wmask     <= '0;
      r_func          <= '0;
      r_off           <= '0;
      r_wen           <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_req_ready     <= (w_state_nxt == S_IDLE);
      r_rsp_valid     <= (w_state_nxt == S_RESP);
      r_mem_req_valid <= (w_state_nxt == S_REQ);

      if (w_accept) begin
        r_func      <= exu.req_func;
        r_off       <= exu.req_addr[1:0];
        r_wen       <= exu.req_wen;
        r_mem_wen   <= exu.req_wen;
        r_mem_addr  <= {exu.req_addr[31:2], 2'b00};
        r_mem_wdata <= exu.req_wdata << {exu.req_addr[1:0], 3'b000};
        r_mem_wmask <= f_wmask(exu.req_wen, exu.req_func, exu.req_addr[1:0]);
        r_rsp_rdata <= '0;
        r_rsp_err   <= w_illegal;
      end

      // A real memory response wins over a watchdog expiry in the same cycle.
      if (w_mem_done) begin
        r_rsp_err   <= mem.rsp_err;
        r_rsp_rdata <= (mem.rsp_err || r_wen) ? 32'd0 : f_load(r_func, r_off, mem.rsp_rdata);
      end else if (w_timeout) begin
        r_rsp_err   <= 1'b1;
        r_rsp_rdata <= '0;
      end

      if ((r_state == S_RESP) && exu.rsp_ready) begin
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= '0;
      end
    end
  end

  assign exu.req_ready = r_req_ready;
  assign exu.rsp_valid = r_rsp_valid;
  assign exu.rsp_rdata = r_rsp_rdata;
  assign exu.rsp_err   = r_rsp_err;
  assign mem.req_valid = r_mem_req_valid;
  assign mem.wen       = r_mem_wen;
  assign mem.addr      = r_mem_addr;
  assign mem.wdata     = r_mem_wdata;
  assign mem.wmask     = r_mem_wmask;

endmodule

// File: tb/tb_ysyx_23060203_lsu.sv
module tb_ysyx_23060203_lsu;

  localparam int unsigned TMO = 8;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  ysyx_23060203_lsu_exu_if exu_bus ();
  ysyx_23060203_lsu_mem_if mem_bus ();

  ysyx_23060203_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .exu (exu_bus),
    .mem (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: byte-level view of a load/store, built from the access rules.
  function automatic void ref_model(input bit wen, input bit [2:0] func, input bit [31:0] addr,
                                    input bit [31:0] wdata, input bit [31:0] word, input bit berr,
                                    output bit ill, output bit [31:0] e_addr,
                                    output bit [31:0] e_wdata, output bit [3:0] e_mask,
                                    output bit [31:0] e_rdata, output bit e_err);
    int off, nbytes;
    bit legal;
    longint v, span;
    off    = int'(addr % 4);
    nbytes = (func[1:0] == 2'd0) ? 1 : (func[1:0] == 2'd1) ? 2 : (func[1:0] == 2'd2) ? 4 : 0;
    legal  = wen ? (func <= 3'd2) : (func <= 3'd2 || func == 3'd4 || func == 3'd5);
    ill    = !legal || (nbytes == 0) || ((off % nbytes) != 0);
    e_addr  = addr - 32'(off);
    e_wdata = 32'(longint'(wdata) * (longint'(1) << (8 * off)));
    for (int i = 0; i < 4; i++) e_mask[i] = wen ? ((i >= off) && (i < off + nbytes)) : 1'b1;
    span = longint'(1) << (8 * nbytes);
    v    = (longint'(word) >> (8 * off)) % span;
    if (!func[2] && nbytes < 4 && v >= span / 2) v = v - span;
    e_rdata = (ill || wen || berr) ? 32'd0 : 32'(v);
    e_err   = ill || berr;
  endfunction

  task automatic run_txn(input bit wen, input bit [2:0] func, input bit [31:0] addr,
                         input bit [31:0] wdata, input bit [31:0] word, input bit berr,
                         input int d_req, input int d_rsp, input int d_ack,
                         input bit noise, input bit early);
    bit        ill, e_err;
    bit [31:0] e_addr, e_wdata, e_rdata;
    bit [3:0]  e_mask;
    ref_model(wen, func, addr, wdata, word, berr, ill, e_addr, e_wdata, e_mask, e_rdata, e_err);

    @(negedge clk);
    chk("req_ready_idle", exu_bus.req_ready, 1);
    exu_bus.req_valid = 1'b1;
    exu_bus.req_wen   = wen;
    exu_bus.req_func  = func;
    exu_bus.req_addr  = addr;
    exu_bus.req_wdata = wdata;
    @(negedge clk);
    exu_bus.req_valid = 1'b0;
    exu_bus.req_wen   = 1'($urandom);
    exu_bus.req_func  = 3'($urandom);
    exu_bus.req_addr  = $urandom;
    exu_bus.req_wdata = $urandom;
    if (early) exu_bus.rsp_ready = 1'b1;

    if (!ill) begin
      for (int i = 0; i <= d_req; i++) begin
        chk("mem_req_valid", mem_bus.req_valid, 1);
        chk("mem_addr", mem_bus.addr, e_addr);
        chk("mem_wen", 32'(mem_bus.wen), 32'(wen));
        chk("mem_wmask", 32'(mem_bus.wmask), 32'(e_mask));
        if (wen) chk("mem_wdata", mem_bus.wdata, e_wdata);
        chk("rsp_valid_req", exu_bus.rsp_valid, 0);
        mem_bus.req_ready = (i == d_req);
        mem_bus.rsp_valid = noise ? 1'($urandom) : 1'b0;
        mem_bus.rsp_rdata = $urandom;
        mem_bus.rsp_err   = 1'($urandom);
        @(negedge clk);
      end
      mem_bus.req_ready = 1'b0;
      mem_bus.rsp_valid = 1'b0;
      chk("mem_req_once", mem_bus.req_valid, 0);
      chk("rsp_valid_wait", exu_bus.rsp_valid, 0);
      repeat (d_rsp) begin
        @(negedge clk);
        chk("rsp_valid_wait", exu_bus.rsp_valid, 0);
      end
      mem_bus.rsp_valid = 1'b1;
      mem_bus.rsp_rdata = word;
      mem_bus.rsp_err   = berr;
      @(negedge clk);
      mem_bus.rsp_valid = 1'b0;
      mem_bus.rsp_rdata = $urandom;
      mem_bus.rsp_err   = 1'b0;
    end else begin
      chk("ill_no_mem_req", mem_bus.req_valid, 0);
    end

    if (early) d_ack = 0;
    for (int i = 0; i <= d_ack; i++) begin
      chk("rsp_valid", exu_bus.rsp_valid, 1);
      chk("rsp_rdata", exu_bus.rsp_rdata, e_rdata);
      chk("rsp_err", 32'(exu_bus.rsp_err), 32'(e_err));
      chk("mem_req_resp", mem_bus.req_valid, 0);
      exu_bus.rsp_ready = (i == d_ack);
      @(negedge clk);
    end
    exu_bus.rsp_ready = 1'b0;
    chk("rsp_done", exu_bus.rsp_valid, 0);
    chk("req_ready_back", exu_bus.req_ready, 1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    exu_bus.req_valid = 0; exu_bus.req_wen = 0; exu_bus.req_func = 0;
    exu_bus.req_addr = 0;  exu_bus.req_wdata = 0; exu_bus.rsp_ready = 0;
    mem_bus.req_ready = 0; mem_bus.rsp_valid = 0; mem_bus.rsp_rdata = 0; mem_bus.rsp_err = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_req_ready", exu_bus.req_ready, 1);
    chk("rst_rsp_valid", exu_bus.rsp_valid, 0);
    chk("rst_rsp_rdata", exu_bus.rsp_rdata, 0);
    chk("rst_rsp_err", exu_bus.rsp_err, 0);
    chk("rst_mem_req_valid", mem_bus.req_valid, 0);
    chk("rst_mem_addr", mem_bus.addr, 0);
    chk("rst_mem_wmask", 32'(mem_bus.wmask), 0);
    chk("rst_mem_wdata", mem_bus.wdata, 0);
    rst = 1'b0;

    // Directed cases
    run_txn(1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0, 1, 0, 0, 0);
    run_txn(1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 32'h0, 0, 1, 0, 1, 0, 0);
    run_txn(0, 3'b000, 32'h8000_0001, 32'h0, 32'h1234_80FF, 0, 0, 0, 0, 0, 0);
    run_txn(0, 3'b100, 32'h8000_0001, 32'h0, 32'h1234_80FF, 0, 0, 2, 0, 1, 0);
    run_txn(0, 3'b101, 32'h8000_0002, 32'h0, 32'h1234_80FF, 0, 2, 0, 0, 0, 1);
    run_txn(0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    run_txn(0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 1, 0, 0);
    run_txn(1, 3'b100, 32'h8000_0000, 32'h55, 32'h0, 0, 0, 0, 0, 0, 1);
    run_txn(0, 3'b010, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 0, 3, 1, 2, 1, 0);
    run_txn(0, 3'b001, 32'h8000_0002, 32'h0, 32'h8765_4321, 1, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      bit [2:0] f;
      f = 3'($urandom);
      run_txn(1'($urandom), f, $urandom, $urandom, $urandom, ($urandom_range(0, 7) == 0),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
              1'($urandom), ($urandom_range(0, 3) == 0));
    end

    // Reset while waiting for memory; a late response must be ignored.
    @(negedge clk);
    exu_bus.req_valid = 1; exu_bus.req_wen = 0; exu_bus.req_func = 3'b010;
    exu_bus.req_addr = 32'h8000_0020;
    @(negedge clk);
    exu_bus.req_valid = 0;
    mem_bus.req_ready = 1;
    @(negedge clk);
    mem_bus.req_ready = 0;
    rst = 1'b1;
    #1;
    chk("midrst_mem_req_valid", mem_bus.req_valid, 0);
    chk("midrst_rsp_valid", exu_bus.rsp_valid, 0);
    chk("midrst_req_ready", exu_bus.req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    mem_bus.rsp_valid = 1; mem_bus.rsp_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_bus.rsp_valid = 0;
    @(negedge clk);
    chk("late_rsp_ignored", exu_bus.rsp_valid, 0);
    chk("late_rsp_idle", exu_bus.req_ready, 1);
    run_txn(0, 3'b000, 32'h8000_0003, 32'h0, 32'h7F00_0000, 0, 0, 0, 0, 0, 0);

`ifdef LSU_TIMEOUT_EN
    // Memory never accepts: the watchdog must abort with an error.
    begin
      int  cyc;
      bit  seen;
      seen = 0;
      cyc  = 0;
      @(negedge clk);
      exu_bus.req_valid = 1; exu_bus.req_wen = 0; exu_bus.req_func = 3'b010;
      exu_bus.req_addr = 32'h8000_0040;
      @(negedge clk);
      exu_bus.req_valid = 0;
      for (int i = 1; i <= 4 * TMO && !seen; i++) begin
        if (exu_bus.rsp_valid) begin seen = 1; cyc = i; end
        else @(negedge clk);
      end
      chk("tmo_seen", 32'(seen), 1);
      chk("tmo_late_enough", 32'(cyc >= int'(TMO)), 1);
      chk("tmo_err", exu_bus.rsp_err, 1);
      chk("tmo_rdata", exu_bus.rsp_rdata, 0);
      chk("tmo_mem_req_dropped", mem_bus.req_valid, 0);
      exu_bus.rsp_ready = 1;
      @(negedge clk);
      exu_bus.rsp_ready = 0;
      chk("tmo_idle", exu_bus.req_ready, 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
